fp_addsub_sched: RTL

FP_ADDSUB_SCHED -- requirements
Module: fp_addsub_sched

---
 rtl/fp_addsub_sched_pkg.sv | 14 +
 rtl/fp_addsub_sched_addsub.sv | 85 ++++++++
 rtl/fp_addsub_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and constants for the fp_addsub_sched scheduler and its datapath.
// Optional round-robin arbitration in the top is enabled with FPU_ARB_RR_EN.
package fp_addsub_sched_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_CANON_NAN = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/fp_addsub_sched_addsub.sv
// Combinational single-precision add/sub datapath: denormals flush to zero,
// round-to-nearest-even on three guard bits, every NaN becomes the canonical NaN.
module Floating_addsub
    import fp_addsub_sched_pkg::*;
(
    input  logic [FP_W-1:0] A,
    input  logic [FP_W-1:0] B,
    input  logic            ADD_SIGNAL,
    output logic [FP_W-1:0] RESULT
);

    logic        sign_a, sign_b, sign_l, sign_s, a_is_large;
    logic        nan_a, nan_b, inf_a, inf_b, round_up;
    logic [7:0]  exp_a, exp_b, exp_l, exp_s, exp_diff;
    logic [23:0] man_a, man_b, man_r;
    logic [26:0] man_l, man_s, norm;
    logic [27:0] sum;
    logic [4:0]  lzc;
    logic [9:0]  exp_r, exp_f;

    always_comb begin
        sign_a = A[31];
        sign_b = B[31] ^ ~ADD_SIGNAL;
        exp_a  = A[30:23];
        exp_b  = B[30:23];
        man_a  = (exp_a == 8'h00) ? 24'd0 : {1'b1, A[22:0]};
        man_b  = (exp_b == 8'h00) ? 24'd0 : {1'b1, B[22:0]};
        nan_a  = (exp_a == 8'hFF) && (A[22:0] != 23'd0);
        nan_b  = (exp_b == 8'hFF) && (B[22:0] != 23'd0);
        inf_a  = (exp_a == 8'hFF) && (A[22:0] == 23'd0);
        inf_b  = (exp_b == 8'hFF) && (B[22:0] == 23'd0);

        // Order by magnitude so the subtraction below never goes negative.
        a_is_large = A[30:0] >= B[30:0];
        sign_l     = a_is_large ? sign_a : sign_b;
        sign_s     = a_is_large ? sign_b : sign_a;
        exp_l      = a_is_large ? exp_a : exp_b;
        exp_s      = a_is_large ? exp_b : exp_a;
        exp_diff   = exp_l - exp_s;
        man_l      = {(a_is_large ? man_a : man_b), 3'b000};
        man_s      = {(a_is_large ? man_b : man_a), 3'b000} >> exp_diff;

        if (sign_l == sign_s) begin
            sum = {1'b0, man_l} + {1'b0, man_s};
        end else begin
            sum = {1'b0, man_l} - {1'b0, man_s};
        end

        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) begin
                lzc = 5'(26 - i);
            end
        end

        if (sum[27]) begin
            norm  = sum[27:1];
            exp_r = {2'b00, exp_l} + 10'd1;
        end else begin
            norm  = sum[26:0] << lzc;
            exp_r = {2'b00, exp_l} - {5'd0, lzc};
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r    = {1'b0, norm[25:3]} + {23'd0, round_up};
        exp_f    = exp_r + {9'd0, man_r[23]};

        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
            RESULT = FP_CANON_NAN;
        end else if (inf_a) begin
            RESULT = {sign_a, 8'hFF, 23'd0};
        end else if (inf_b) begin
            RESULT = {sign_b, 8'hFF, 23'd0};
        end else if (!norm[26]) begin
            RESULT = '0;
        end else if ($signed(exp_f) <= 10'sd0) begin
            RESULT = {sign_l, 31'd0};
        end else if ($signed(exp_f) >= 10'sd255) begin
            RESULT = {sign_l, 8'hFF, 23'd0};
        end else begin
            RESULT = {sign_l, exp_f[7:0], man_r[22:0]};
        end
    end

endmodule

// File: rtl/fp_addsub_sched.sv
// Two-requester scheduler around one shared FP add/sub datapath.
// Define FPU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fp_addsub_sched
    import fp_addsub_sched_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [FP_W-1:0] req0_a,
    input  logic [FP_W-1:0] req0_b,
    input  logic [FP_W-1:0] req1_a,
    input  logic [FP_W-1:0] req1_b,
    input  logic            req0_add,
    input  logic            req1_add,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [FP_W-1:0] rsp_data,
    output logic            rsp_id,
    output logic            busy
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [FP_W-1:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d, dp_result;
    logic            add_q, add_d, id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic            grant1, accept;
`ifdef FPU_ARB_RR_EN
    logic            rr_q, rr_d;
`endif

    // Ready is gated by rst_n so it drops the instant reset is asserted.
    always_comb begin
`ifdef FPU_ARB_RR_EN
        grant1 = req1_valid && (!req0_valid || !rr_q);
`else
        grant1 = req1_valid && !req0_valid;
`endif
        accept = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    end

    assign req0_ready = accept && !grant1;
    assign req1_ready = accept && grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);

    Floating_addsub u_dp (
        .A          (a_q),
        .B          (b_q),
        .ADD_SIGNAL (add_q),
        .RESULT     (dp_result)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        add_d       = add_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
`ifdef FPU_ARB_RR_EN
        rr_d        = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    add_d   = grant1 ? req1_add : req0_add;
                    id_d    = grant1;
                    cnt_d   = EXEC_LOAD;
                    state_d = EXEC;
`ifdef FPU_ARB_RR_EN
                    rr_d    = grant1;
`endif
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = dp_result;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            add_q       <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
`ifdef FPU_ARB_RR_EN
            rr_q        <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            add_q       <= add_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
`ifdef FPU_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

endmodule
